alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports i_req0_valid / i_req1_valid  input  1  requester N presents an operation.
REQ-004 SHALL have ports i_reqN_operation  input  t_alu_operation  operation requested by N.
REQ-005 SHALL have ports i_reqN_operand1, i_reqN_operand2  input  t_data (32)  operands from N.
REQ-006 SHALL have ports o_reqN_ready  output  1  request from N accepted this cycle.
REQ-007 SHALL have ports o_rspN_valid  output  1  result for N available.
REQ-008 SHALL have ports o_rspN_result  output  t_data (32)  registered ALU result.
REQ-009 SHALL have ports o_rspN_zero  output  1  registered ALU zero flag.
REQ-010 SHALL have ports i_rspN_ready  input  1  requester N consumes response.
REQ-011 SHALL have ports o_alu_operation  output  t_alu_operation; o_alu_operand1, o_alu_operand2  output  t_data  registered drive to shared ALU.
REQ-012 SHALL have ports i_alu_result  input  t_data; i_alu_zero  input  1  combinational ALU outputs.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP; exactly one active.
REQ-014 In IDLE, SHALL assert o_reqN_ready combinationally only for the grantee; no ready in EXEC/RESP.
REQ-015 Grant: if one valid, that requester; if both valid, per arbitration policy (REQ-027/028); none valid -> no grant, stay IDLE.
REQ-016 On valid && ready (accept), SHALL latch operation/operands into o_alu_* registers, store grant id, go to EXEC.
REQ-017 In EXEC, SHALL capture i_alu_result/i_alu_zero into result/zero registers, go to RESP.
REQ-018 In RESP, SHALL assert o_rspN_valid for stored grant id only; other o_rsp valid SHALL be 0.
REQ-019 RESP SHALL hold result, zero and valid stable until i_rspN_ready=1 for the grantee; then go to IDLE next cycle.
REQ-020 Latency: accept in cycle T -> o_rspN_valid high in cycle T+2; minimum issue interval 3 cycles.
REQ-021 o_rspN_result/o_rspN_zero SHALL both be driven from the shared result register; meaningful only while o_rspN_valid.
REQ-022 o_alu_* SHALL remain unchanged outside accept cycles.
REQ-023 Requesters SHALL hold valid and payload stable until ready; dropping valid before ready is legal and results in no accept.

Reset
REQ-024 i_reset=1 on a clock edge SHALL force IDLE from any state, discarding in-flight operation and pending response.
REQ-025 Reset values: o_reqN_ready=0 (no valid), o_rspN_valid=0, results 0, zero flag 0, o_alu_operation=ALU_OP_ADD, o_alu_operands=0, last grant=1.
REQ-026 Reset asserted in RESP with i_rspN_ready=1 in the same cycle SHALL NOT count as a completed handshake-driven transition; state is IDLE next cycle.

Configuration
REQ-027 With ALU_ARB_ROUND_ROBIN_EN defined: both valid -> grant requester other than last-granted; last-grant register updates on each accept.
REQ-028 Without ALU_ARB_ROUND_ROBIN_EN: fixed priority, requester 0 wins whenever both valid; last-grant register absent or unused.

Verification
REQ-029 req0 ADD 5,7 alone at T -> o_req0_ready at T, o_rsp0_valid at T+2, result 12, zero 0.
REQ-030 Both valid from reset, req0 SUB 3,3, req1 XOR 0xF0,0x0F, RR build -> req0 first (result 0, zero 1), then req1 (result 0xFF, zero 0).
REQ-031 RR build, both held valid for 4 ops -> grants alternate 0,1,0,1; fixed build -> all grants to 0 while req0 valid.
REQ-032 req1 SHIFT_RIGHT_ARITH 0x80000000,4, i_rsp1_ready low 5 cycles -> o_rsp1_valid and result 0xF8000000 held stable 5 cycles, IDLE one cycle after ready.
REQ-033 Reset pulsed in EXEC -> next cycle IDLE, no o_rsp valid, o_alu_operation=ALU_OP_ADD, operands 0.
REQ-034 req0 valid while FSM in RESP -> o_req0_ready stays 0 until FSM returns to IDLE.

Source files
------------

// File: rtl/alu_arbiter.sv
// Purpose: arbitrates two requesters onto one shared combinational ALU and returns the result to the winner.
// Latency: accept in cycle T, response valid in cycle T+2; one operation in flight, so a new accept is possible every 3 cycles at best.
// Backpressure: ready is offered only in IDLE; the response is held until the grantee's i_rspN_ready, and no new request is accepted meanwhile.
// Optional feature: ALU_ARB_ROUND_ROBIN_EN selects round-robin arbitration; the default build uses fixed priority with requester 0 winning.

typedef logic [31:0] t_data;

typedef enum logic [3:0] {
    ALU_OP_ADD               = 4'd0,
    ALU_OP_SUB               = 4'd1,
    ALU_OP_AND               = 4'd2,
    ALU_OP_OR                = 4'd3,
    ALU_OP_XOR               = 4'd4,
    ALU_OP_SHIFT_LEFT        = 4'd5,
    ALU_OP_SHIFT_RIGHT       = 4'd6,
    ALU_OP_SHIFT_RIGHT_ARITH = 4'd7,
    ALU_OP_SLT               = 4'd8,
    ALU_OP_SLTU              = 4'd9
} t_alu_operation;

module alu_arbiter (
    input  logic           i_clk,
    input  logic           i_reset,

    input  logic           i_req0_valid,
    input  t_alu_operation i_req0_operation,
    input  t_data          i_req0_operand1,
    input  t_data          i_req0_operand2,
    output logic           o_req0_ready,

    input  logic           i_req1_valid,
    input  t_alu_operation i_req1_operation,
    input  t_data          i_req1_operand1,
    input  t_data          i_req1_operand2,
    output logic           o_req1_ready,

    output logic           o_rsp0_valid,
    output t_data          o_rsp0_result,
    output logic           o_rsp0_zero,
    input  logic           i_rsp0_ready,

    output logic           o_rsp1_valid,
    output t_data          o_rsp1_result,
    output logic           o_rsp1_zero,
    input  logic           i_rsp1_ready,

    output t_alu_operation o_alu_operation,
    output t_data          o_alu_operand1,
    output t_data          o_alu_operand2,
    input  t_data          i_alu_result,
    input  logic           i_alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } t_state;

    t_state         r_state;
    t_state         w_state_next;

    // Requester that owns the operation currently in flight (0 or 1).
    logic           r_grant_id;

    t_alu_operation r_alu_operation;
    t_data          r_alu_operand1;
    t_data          r_alu_operand2;

    // Single result/zero pair shared by both response ports.
    t_data          r_result;
    logic           r_zero;

    logic           w_grant_valid;
    logic           w_grant_id;
    logic           w_accept;
    logic           w_rsp_ready;

    t_alu_operation w_sel_operation;
    t_data          w_sel_operand1;
    t_data          w_sel_operand2;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Requester granted most recently; the other one wins the next tie.
    logic           r_last_grant;
`endif

    // Arbitration: a lone requester wins; a tie goes by the configured policy.
    always_comb begin
        w_grant_valid = i_req0_valid | i_req1_valid;
        w_grant_id    = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            w_grant_id = ~r_last_grant;
`else
            w_grant_id = 1'b0;
`endif
        end else if (i_req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    // Payload of the winning requester, loaded into the ALU drive registers on accept.
    always_comb begin
        w_sel_operation = i_req0_operation;
        w_sel_operand1  = i_req0_operand1;
        w_sel_operand2  = i_req0_operand2;
        if (w_grant_id) begin
            w_sel_operation = i_req1_operation;
            w_sel_operand1  = i_req1_operand1;
            w_sel_operand2  = i_req1_operand2;
        end
    end

    // Next-state and handshake decode: ready only in IDLE, response valid only in RESP.
    always_comb begin
        w_state_next = r_state;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_rsp0_valid = 1'b0;
        o_rsp1_valid = 1'b0;
        w_accept     = 1'b0;
        w_rsp_ready  = r_grant_id ? i_rsp1_ready : i_rsp0_ready;

        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    // Grant is only ever given to a valid requester, so ready implies accept.
                    o_req0_ready = ~w_grant_id;
                    o_req1_ready = w_grant_id;
                    w_accept     = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                o_rsp0_valid = ~r_grant_id;
                o_rsp1_valid = r_grant_id;
                if (w_rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight operation or pending response.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ALU drive registers and owner id: loaded on accept only, otherwise held.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_alu_operation <= ALU_OP_ADD;
            r_alu_operand1  <= '0;
            r_alu_operand2  <= '0;
            r_grant_id      <= 1'b0;
        end else if (w_accept) begin
            r_alu_operation <= w_sel_operation;
            r_alu_operand1  <= w_sel_operand1;
            r_alu_operand2  <= w_sel_operand2;
            r_grant_id      <= w_grant_id;
        end
    end

    // Result capture: the ALU settles during EXEC from the registered drive.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_result <= i_alu_result;
            r_zero   <= i_alu_zero;
        end
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Round-robin history: remembers the winner of every accept.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
        end
    end
`endif

    assign o_alu_operation = r_alu_operation;
    assign o_alu_operand1  = r_alu_operand1;
    assign o_alu_operand2  = r_alu_operand2;

    assign o_rsp0_result   = r_result;
    assign o_rsp0_zero     = r_zero;
    assign o_rsp1_result   = r_result;
    assign o_rsp1_zero     = r_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic from two requesters.
// Drivers push expected results per requester; a negedge monitor predicts handshakes and scores responses.
// The shared ALU is modelled combinationally from the DUT's registered ALU drive.

module tb_alu_arbiter;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        z;
    } t_exp;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
        int          lat;
    } t_rsp_rec;

    logic           i_clk = 1'b0;
    logic           i_reset;
    logic           i_req0_valid, i_req1_valid;
    t_alu_operation i_req0_operation, i_req1_operation;
    t_data          i_req0_operand1, i_req0_operand2, i_req1_operand1, i_req1_operand2;
    logic           o_req0_ready, o_req1_ready;
    logic           o_rsp0_valid, o_rsp1_valid;
    t_data          o_rsp0_result, o_rsp1_result;
    logic           o_rsp0_zero, o_rsp1_zero;
    logic           i_rsp0_ready, i_rsp1_ready;
    t_alu_operation o_alu_operation;
    t_data          o_alu_operand1, o_alu_operand2;
    t_data          i_alu_result;
    logic           i_alu_zero;

    int checks = 0;
    int passes = 0;

    // Reference model state
    t_exp     q0[$];
    t_exp     q1[$];
    t_rsp_rec rsp_log[$];
    int       grant_log[$];
    bit       busy   = 1'b0;
    int       cur    = 0;
    int       acc_cyc = 0;
    int       last_g = 1;
    int       cyc    = 0;
    bit       rand_done = 1'b0;

    always #5 i_clk = ~i_clk;

    alu_arbiter dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req0_valid(i_req0_valid), .i_req0_operation(i_req0_operation),
        .i_req0_operand1(i_req0_operand1), .i_req0_operand2(i_req0_operand2), .o_req0_ready(o_req0_ready),
        .i_req1_valid(i_req1_valid), .i_req1_operation(i_req1_operation),
        .i_req1_operand1(i_req1_operand1), .i_req1_operand2(i_req1_operand2), .o_req1_ready(o_req1_ready),
        .o_rsp0_valid(o_rsp0_valid), .o_rsp0_result(o_rsp0_result), .o_rsp0_zero(o_rsp0_zero), .i_rsp0_ready(i_rsp0_ready),
        .o_rsp1_valid(o_rsp1_valid), .o_rsp1_result(o_rsp1_result), .o_rsp1_zero(o_rsp1_zero), .i_rsp1_ready(i_rsp1_ready),
        .o_alu_operation(o_alu_operation), .o_alu_operand1(o_alu_operand1), .o_alu_operand2(o_alu_operand2),
        .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero)
    );

    // Arithmetic meaning of each operation; returns {zero, result}.
    function automatic logic [32:0] ref_alu(input t_alu_operation op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_OP_ADD:               r = a + b;
            ALU_OP_SUB:               r = a - b;
            ALU_OP_AND:               r = a & b;
            ALU_OP_OR:                r = a | b;
            ALU_OP_XOR:               r = a ^ b;
            ALU_OP_SHIFT_LEFT:        r = a << b[4:0];
            ALU_OP_SHIFT_RIGHT:       r = a >> b[4:0];
            ALU_OP_SHIFT_RIGHT_ARITH: r = 32'($signed(a) >>> b[4:0]);
            ALU_OP_SLT:               r = {31'd0, $signed(a) < $signed(b)};
            ALU_OP_SLTU:              r = {31'd0, a < b};
            default:                  r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    // Shared ALU seen by the DUT
    logic [32:0] alu_rz;
    always_comb alu_rz = ref_alu(o_alu_operation, o_alu_operand1, o_alu_operand2);
    assign i_alu_result = alu_rz[31:0];
    assign i_alu_zero   = alu_rz[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_clear();
        busy   = 1'b0;
        last_g = 1;
        q0.delete();
        q1.delete();
    endtask

    // Monitor: predicts ready/valid each cycle and scores responses against the scoreboard.
    always @(negedge i_clk) begin
        bit pick0, e_r0, e_r1, v0, v1;
        t_rsp_rec rec;
        cyc++;
        if (!i_reset) begin
            pick0 = RR ? (last_g == 1) : 1'b1;
            e_r0  = !busy && i_req0_valid && (!i_req1_valid || pick0);
            e_r1  = !busy && i_req1_valid && !e_r0;
            chk("req0_ready", o_req0_ready, e_r0);
            chk("req1_ready", o_req1_ready, e_r1);
            v0 = busy && cur == 0 && (cyc - acc_cyc) >= 2;
            v1 = busy && cur == 1 && (cyc - acc_cyc) >= 2;
            chk("rsp0_valid", o_rsp0_valid, v0);
            chk("rsp1_valid", o_rsp1_valid, v1);
            if (v0 && o_rsp0_valid) begin
                chk("rsp0_pending", q0.size() > 0, 1);
                if (q0.size() > 0) begin
                    chk("rsp0_result", o_rsp0_result, q0[0].res);
                    chk("rsp0_zero", o_rsp0_zero, q0[0].z);
                    if (i_rsp0_ready) begin
                        rec = '{id: 0, res: o_rsp0_result, z: o_rsp0_zero, lat: cyc - acc_cyc};
                        rsp_log.push_back(rec);
                        void'(q0.pop_front());
                        busy = 1'b0;
                    end
                end
            end
            if (v1 && o_rsp1_valid) begin
                chk("rsp1_pending", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    chk("rsp1_result", o_rsp1_result, q1[0].res);
                    chk("rsp1_zero", o_rsp1_zero, q1[0].z);
                    if (i_rsp1_ready) begin
                        rec = '{id: 1, res: o_rsp1_result, z: o_rsp1_zero, lat: cyc - acc_cyc};
                        rsp_log.push_back(rec);
                        void'(q1.pop_front());
                        busy = 1'b0;
                    end
                end
            end
            if ((o_req0_ready && i_req0_valid) || (o_req1_ready && i_req1_valid)) begin
                cur     = (o_req1_ready && i_req1_valid) ? 1 : 0;
                busy    = 1'b1;
                acc_cyc = cyc;
                last_g  = cur;
                grant_log.push_back(cur);
            end
        end
    end

    // Present one operation on requester n; called just after a rising edge.
    task automatic issue(input int n, input t_alu_operation op, input logic [31:0] a, input logic [31:0] b,
                         input int max_wait, input bit may_drop);
        logic [32:0] r;
        t_exp e;
        bit got;
        r = ref_alu(op, a, b);
        e = '{res: r[31:0], z: r[32]};
        if (n == 0) begin
            i_req0_valid = 1'b1; i_req0_operation = op; i_req0_operand1 = a; i_req0_operand2 = b;
            q0.push_back(e);
        end else begin
            i_req1_valid = 1'b1; i_req1_operation = op; i_req1_operand1 = a; i_req1_operand2 = b;
            q1.push_back(e);
        end
        got = 1'b0;
        for (int k = 0; k < max_wait && !got; k++) begin
            @(negedge i_clk);
            got = (n == 0) ? o_req0_ready : o_req1_ready;
        end
        @(posedge i_clk);
        #1;
        if (n == 0) i_req0_valid = 1'b0; else i_req1_valid = 1'b0;
        if (!got) begin
            if (n == 0) void'(q0.pop_back()); else void'(q1.pop_back());
            if (!may_drop) chk($sformatf("req%0d_accept_timeout", n), got, 1);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge i_clk);
        #1;
        while ((busy || q0.size() != 0 || q1.size() != 0) && k < 200) begin
            @(negedge i_clk);
            #1;
            k++;
        end
        chk(name, k < 200, 1);
    endtask

    task automatic rand_driver(input int n, input int nops);
        t_alu_operation op;
        logic [31:0] a, b;
        for (int i = 0; i < nops; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
            op = t_alu_operation'(4'($urandom_range(0, 9)));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 7) == 0) issue(n, op, a, b, 1, 1'b1);
            else                           issue(n, op, a, b, 200, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int exp_g[4];
        int n;
        i_reset = 1'b1;
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        i_req0_operation = ALU_OP_ADD; i_req1_operation = ALU_OP_ADD;
        i_req0_operand1 = '0; i_req0_operand2 = '0; i_req1_operand1 = '0; i_req1_operand2 = '0;
        i_rsp0_ready = 1'b1; i_rsp1_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;

        // Reset values
        @(negedge i_clk);
        chk("rst_req0_ready", o_req0_ready, 0);
        chk("rst_req1_ready", o_req1_ready, 0);
        chk("rst_rsp0_valid", o_rsp0_valid, 0);
        chk("rst_rsp1_valid", o_rsp1_valid, 0);
        chk("rst_rsp0_result", o_rsp0_result, 0);
        chk("rst_rsp1_result", o_rsp1_result, 0);
        chk("rst_rsp0_zero", o_rsp0_zero, 0);
        chk("rst_rsp1_zero", o_rsp1_zero, 0);
        chk("rst_alu_op", 32'(o_alu_operation), 32'(ALU_OP_ADD));
        chk("rst_alu_opnd1", o_alu_operand1, 0);
        chk("rst_alu_opnd2", o_alu_operand2, 0);

        // Both valid straight out of reset: requester 0 first, then requester 1
        @(posedge i_clk); #1;
        rsp_log.delete(); grant_log.delete();
        fork
            issue(0, ALU_OP_SUB, 32'd3, 32'd3, 200, 1'b0);
            issue(1, ALU_OP_XOR, 32'hF0, 32'h0F, 200, 1'b0);
        join
        wait_idle("both_drain");
        chk("both_count", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            chk("both_first_id", rsp_log[0].id, 0);
            chk("both_first_res", rsp_log[0].res, 32'h0);
            chk("both_first_zero", rsp_log[0].z, 1);
            chk("both_second_id", rsp_log[1].id, 1);
            chk("both_second_res", rsp_log[1].res, 32'hFF);
            chk("both_second_zero", rsp_log[1].z, 0);
        end

        // Both held valid for four operations
        if (RR) exp_g = '{0, 1, 0, 1};
        else    exp_g = '{0, 0, 1, 1};
        @(posedge i_clk); #1;
        grant_log.delete();
        fork
            begin
                issue(0, ALU_OP_ADD, 32'd10, 32'd1, 200, 1'b0);
                issue(0, ALU_OP_OR, 32'h100, 32'h1, 200, 1'b0);
            end
            begin
                issue(1, ALU_OP_SUB, 32'd1, 32'd2, 200, 1'b0);
                issue(1, ALU_OP_SLTU, 32'd1, 32'd2, 200, 1'b0);
            end
        join
        wait_idle("alt_drain");
        chk("alt_count", grant_log.size(), 4);
        n = (grant_log.size() < 4) ? grant_log.size() : 4;
        for (int i = 0; i < n; i++) chk($sformatf("alt_grant%0d", i), grant_log[i], exp_g[i]);

        // Lone request: ADD 5,7 with response two cycles after accept
        @(posedge i_clk); #1;
        rsp_log.delete();
        issue(0, ALU_OP_ADD, 32'd5, 32'd7, 200, 1'b0);
        wait_idle("add_drain");
        chk("add_count", rsp_log.size(), 1);
        if (rsp_log.size() == 1) begin
            chk("add_id", rsp_log[0].id, 0);
            chk("add_res", rsp_log[0].res, 32'd12);
            chk("add_zero", rsp_log[0].z, 0);
            chk("add_latency", rsp_log[0].lat, 2);
        end

        // Response stalled five cycles while requester 0 waits
        @(posedge i_clk); #1;
        i_rsp1_ready = 1'b0;
        issue(1, ALU_OP_SHIFT_RIGHT_ARITH, 32'h8000_0000, 32'd4, 200, 1'b0);
        fork
            issue(0, ALU_OP_OR, 32'h0F0, 32'h00F, 200, 1'b0);
        join_none
        n = 0;
        while (!o_rsp1_valid && n < 20) begin @(negedge i_clk); n++; end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_valid%0d", k), o_rsp1_valid, 1);
            chk($sformatf("stall_res%0d", k), o_rsp1_result, 32'hF800_0000);
            chk($sformatf("stall_req0_rdy%0d", k), o_req0_ready, 0);
            if (k < 4) @(negedge i_clk);
        end
        @(posedge i_clk); #1;
        i_rsp1_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("stall_after_valid", o_rsp1_valid, 0);
        chk("stall_after_req0_rdy", o_req0_ready, 1);
        wait_idle("stall_drain");

        // Reset during EXEC discards the operation
        @(posedge i_clk); #1;
        i_req0_valid = 1'b1; i_req0_operation = ALU_OP_SUB;
        i_req0_operand1 = 32'd9; i_req0_operand2 = 32'd4;
        n = 0;
        do begin @(negedge i_clk); n++; end while (!o_req0_ready && n < 20);
        chk("exec_rst_accept", o_req0_ready, 1);
        @(posedge i_clk); #1;
        i_req0_valid = 1'b0;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        model_clear();
        @(negedge i_clk);
        chk("exec_rst_rsp0", o_rsp0_valid, 0);
        chk("exec_rst_rsp1", o_rsp1_valid, 0);
        chk("exec_rst_op", 32'(o_alu_operation), 32'(ALU_OP_ADD));
        chk("exec_rst_opnd1", o_alu_operand1, 0);
        chk("exec_rst_opnd2", o_alu_operand2, 0);
        @(negedge i_clk);
        chk("exec_rst_rsp0_later", o_rsp0_valid, 0);

        // Reset in RESP together with the response handshake
        @(posedge i_clk); #1;
        i_rsp1_ready = 1'b0;
        issue(1, ALU_OP_AND, 32'hFFFF_0000, 32'h00FF_00FF, 200, 1'b0);
        n = 0;
        while (!o_rsp1_valid && n < 20) begin @(negedge i_clk); n++; end
        chk("resp_rst_valid", o_rsp1_valid, 1);
        @(posedge i_clk); #1;
        i_rsp1_ready = 1'b1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        model_clear();
        fork
            issue(1, ALU_OP_ADD, 32'd1, 32'd1, 200, 1'b0);
        join_none
        @(negedge i_clk);
        chk("resp_rst_rsp1", o_rsp1_valid, 0);
        chk("resp_rst_idle", o_req1_ready, 1);
        wait_idle("resp_rst_drain");

        // Randomized traffic from both requesters
        @(posedge i_clk); #1;
        fork
            begin
                fork
                    rand_driver(0, 40);
                    rand_driver(1, 40);
                join
                wait_idle("rand_drain");
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge i_clk); #1;
                    i_rsp0_ready = ($urandom_range(0, 3) != 0);
                    i_rsp1_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
